// File: rtl/display_bin_formatter_if.sv
// Bus between the datapath and the digit formatter: conversion request
// and value on one side, per-digit display codes and status on the other.
interface display_bin_formatter_if #(
  parameter int WIDTH  = 20,
  parameter int DIGITS = 6
);
  logic                  start;
  logic [WIDTH-1:0]      value;
  logic                  hex_mode;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [5*DIGITS-1:0]   digit_value;
  logic [DIGITS-1:0]     digit_enable;

  // Requester side: issues conversions, watches results.
  modport master (
    output start, value, hex_mode,
    input  busy, done, overflow, digit_value, digit_enable
  );

  // Formatter side: accepts conversions, drives the decoder bank.
  modport slave (
    input  start, value, hex_mode,
    output busy, done, overflow, digit_value, digit_enable
  );
endinterface

// File: rtl/display_bin_formatter.sv
// Signed binary to seven-segment digit codes. Decimal uses an iterative
// shift-add-3 conversion (one bit per clock), hex slices nibbles directly.
// Outputs are registered once per conversion, so the display only ever
// shows complete results.
module display_bin_formatter #(
  parameter int WIDTH  = 20,
  parameter int DIGITS = 6
) (
  input logic                    clk,
  input logic                    rst_n,
  display_bin_formatter_if.slave bus
);

  // Enough BCD digits for any WIDTH-bit magnitude, plus one spare:
  // ceil(WIDTH*log10(2)) + 1, computed with integer arithmetic.
  localparam int BCD_DIGITS = (WIDTH * 30103 + 99999) / 100000 + 1;
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int CNT_W      = $clog2(WIDTH + 1);
  localparam logic [4:0] MINUS_CODE = 5'h10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_FORMAT
  } state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    mag_q,   mag_d;    // magnitude (decimal) or raw value (hex)
  logic [BCD_W-1:0]    bcd_q,   bcd_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic                sign_q,  sign_d;
  logic                hex_q,   hex_d;
  logic                busy_q,  busy_d;
  logic                done_q,  done_d;
  logic                ovf_q,   ovf_d;
  logic [5*DIGITS-1:0] dv_q,    dv_d;
  logic [DIGITS-1:0]   en_q,    en_d;

  logic [BCD_W-1:0]    bcd_adj;
  logic [5*DIGITS-1:0] fmt_dv;
  logic [DIGITS-1:0]   fmt_en;
  logic                fmt_ovf;
  int                  top;

  // Add 3 to every BCD digit that is 5 or more, ahead of the next shift.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign bcd_adj = add3(bcd_q);

  // Build the display image from the finished conversion registers.
  always_comb begin
    // NOTE: every variable gets a default before any branch so the block
    // stays purely combinational; a missed path would infer a latch.
    fmt_dv  = '0;
    fmt_en  = '0;
    fmt_ovf = 1'b0;
    top     = 0;
    if (hex_q) begin
      // Nibbles past the top of the value shift in as zero, so they never
      // raise the leading-digit index and stay dark.
      for (int i = 0; i < DIGITS; i++) begin
        fmt_dv[5*i +: 5] = {1'b0, 4'(mag_q >> (4*i))};
        if (4'(mag_q >> (4*i)) != 4'h0) top = i;
      end
      for (int i = 0; i < DIGITS; i++) fmt_en[i] = (i <= top);
    end else begin
      for (int i = DIGITS; i < BCD_DIGITS; i++) begin
        if (4'(bcd_q >> (4*i)) != 4'h0) fmt_ovf = 1'b1;
      end
      // A negative number needs the top digit for its minus sign.
      if (sign_q && (4'(bcd_q >> (4*(DIGITS-1))) != 4'h0)) fmt_ovf = 1'b1;

      if (fmt_ovf) begin
        for (int i = 0; i < DIGITS; i++) fmt_dv[5*i +: 5] = MINUS_CODE;
        fmt_en = '1;
      end else begin
        for (int i = 0; i < DIGITS; i++) begin
          fmt_dv[5*i +: 5] = {1'b0, 4'(bcd_q >> (4*i))};
          if (4'(bcd_q >> (4*i)) != 4'h0) top = i;
        end
        for (int i = 0; i < DIGITS; i++) fmt_en[i] = (i <= top);
        // No overflow with a sign means digit DIGITS-1 was zero, so the
        // minus always lands inside the display.
        if (sign_q && (top + 1 < DIGITS)) begin
          fmt_dv[5*(top+1) +: 5] = MINUS_CODE;
          fmt_en[top+1]          = 1'b1;
        end
      end
    end
  end

  // Next-state and datapath updates for the IDLE/SHIFT/FORMAT sequence.
  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    hex_d   = hex_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    dv_d    = dv_q;
    en_d    = en_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          sign_d  = bus.value[WIDTH-1];
          hex_d   = bus.hex_mode;
          // Hex shows the raw bit pattern; decimal works on |value|. The
          // unsigned negate maps the most-negative value to 2^(WIDTH-1).
          mag_d   = bus.hex_mode ? bus.value
                  : (bus.value[WIDTH-1] ? -bus.value : bus.value);
          bcd_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = bus.hex_mode ? S_FORMAT : S_SHIFT;
        end
      end
      S_SHIFT: begin
        {bcd_d, mag_d} = {bcd_adj, mag_q} << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FORMAT;
      end
      S_FORMAT: begin
        dv_d    = fmt_dv;
        en_d    = fmt_en;
        ovf_d   = fmt_ovf;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Conversion and output registers; reset blanks the display and drops
  // any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      sign_q <= 1'b0;
      hex_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
      dv_q   <= '0;
      en_q   <= '0;
    end else begin
      mag_q  <= mag_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      sign_q <= sign_d;
      hex_q  <= hex_d;
      busy_q <= busy_d;
      done_q <= done_d;
      ovf_q  <= ovf_d;
      dv_q   <= dv_d;
      en_q   <= en_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.overflow     = ovf_q;
  assign bus.digit_value  = dv_q;
  assign bus.digit_enable = en_q;

endmodule

// File: tb/tb_display_bin_formatter.sv
// Bench for display_bin_formatter: table of known conversions, a few
// random values against an arithmetic model, and hand-written sequences
// for busy-time starts, FORMAT-edge starts and mid-conversion reset.
module tb_display_bin_formatter;
  localparam int W   = 20;
  localparam int D   = 6;
  localparam int DVW = 5 * D;
  localparam logic [4:0] M = 5'h10;

  typedef struct {
    logic [DVW-1:0] dv;
    logic [D-1:0]   en;
    logic           ovf;
  } exp_t;

  typedef struct {
    logic [W-1:0]   value;
    logic           hex;
    logic [DVW-1:0] dv;
    logic [D-1:0]   en;
    logic           ovf;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  display_bin_formatter_if #(.WIDTH(W), .DIGITS(D)) bus ();

  display_bin_formatter #(.WIDTH(W), .DIGITS(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t sb_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DVW-1:0] dv6(input logic [4:0] d5, d4, d3, d2, d1, d0);
    return {d5, d4, d3, d2, d1, d0};
  endfunction

  // Reference built from integer division, independent of shift-add-3.
  function automatic exp_t model(input logic [W-1:0] v, input logic hex);
    exp_t r;
    int   dg[D];
    int   sv, mag, top;
    r.dv = '0; r.en = '0; r.ovf = 1'b0; top = 0;
    for (int i = 0; i < D; i++) dg[i] = 0;
    if (hex) begin
      for (int i = 0; i < D; i++) dg[i] = int'((v >> (4*i)) & 20'hF);
    end else begin
      sv  = int'($signed(v));
      mag = (sv < 0) ? -sv : sv;
      if (mag >= 1000000 || (sv < 0 && mag >= 100000)) begin
        r.ovf = 1'b1;
        for (int i = 0; i < D; i++) r.dv[5*i +: 5] = M;
        r.en = '1;
        return r;
      end
      for (int i = 0; i < D; i++) begin
        dg[i] = mag % 10;
        mag   = mag / 10;
      end
    end
    for (int i = 0; i < D; i++) if (dg[i] != 0) top = i;
    for (int i = 0; i < D; i++) begin
      r.dv[5*i +: 5] = 5'(dg[i]);
      r.en[i]        = (i <= top);
    end
    if (!hex && int'($signed(v)) < 0) begin
      r.dv[5*(top+1) +: 5] = M;
      r.en[top+1]          = 1'b1;
    end
    return r;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest request.
  always @(posedge clk) begin
    #1;
    if (bus.done === 1'b1) begin
      check("sb_nonempty", sb_q.size() > 0, 1);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        check("digit_value",  bus.digit_value,  mon_e.dv);
        check("digit_enable", bus.digit_enable, mon_e.en);
        check("overflow",     bus.overflow,     mon_e.ovf);
      end
    end
  end

  // One full conversion: latency, busy window and single-cycle done.
  task automatic convert(input logic [W-1:0] v, input logic hex, input exp_t e);
    int   n;
    logic busy_ok;
    @(negedge clk);
    bus.value    = v;
    bus.hex_mode = hex;
    bus.start    = 1'b1;
    sb_q.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b0;
    busy_ok   = bus.busy;
    n         = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (bus.done !== 1'b1 && bus.busy !== 1'b1) busy_ok = 1'b0;
    end
    check("latency", n, hex ? 1 : W + 1);
    check("busy_window", busy_ok, 1'b1);
    check("busy_at_done", bus.busy, 1'b0);
    @(posedge clk); #1;
    check("done_one_cycle", bus.done, 1'b0);
  endtask

  vec_t tbl[16];
  exp_t e;
  logic [W-1:0] rv;
  logic         rh;
  int           n, extra;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start    = 1'b0;
    bus.value    = '0;
    bus.hex_mode = 1'b0;

    tbl[0]  = '{20'd12345,    1'b0, dv6(0, 1, 2, 3, 4, 5), 6'b011111, 1'b0};
    tbl[1]  = '{20'(-42),     1'b0, dv6(0, 0, 0, M, 4, 2), 6'b000111, 1'b0};
    tbl[2]  = '{20'd0,        1'b0, dv6(0, 0, 0, 0, 0, 0), 6'b000001, 1'b0};
    tbl[3]  = '{20'(-99999),  1'b0, dv6(M, 9, 9, 9, 9, 9), 6'b111111, 1'b0};
    tbl[4]  = '{20'(-100000), 1'b0, dv6(M, M, M, M, M, M), 6'b111111, 1'b1};
    tbl[5]  = '{20'h80000,    1'b0, dv6(M, M, M, M, M, M), 6'b111111, 1'b1};
    tbl[6]  = '{20'd524287,   1'b0, dv6(5, 2, 4, 2, 8, 7), 6'b111111, 1'b0};
    tbl[7]  = '{20'd7,        1'b0, dv6(0, 0, 0, 0, 0, 7), 6'b000001, 1'b0};
    tbl[8]  = '{20'(-1),      1'b0, dv6(0, 0, 0, 0, M, 1), 6'b000011, 1'b0};
    tbl[9]  = '{20'd100000,   1'b0, dv6(1, 0, 0, 0, 0, 0), 6'b111111, 1'b0};
    tbl[10] = '{20'(-10000),  1'b0, dv6(M, 1, 0, 0, 0, 0), 6'b111111, 1'b0};
    tbl[11] = '{20'hA0F03,    1'b1, dv6(0, 5'hA, 0, 5'hF, 0, 3), 6'b011111, 1'b0};
    tbl[12] = '{20'h00F00,    1'b1, dv6(0, 0, 0, 5'hF, 0, 0), 6'b000111, 1'b0};
    tbl[13] = '{20'h00000,    1'b1, dv6(0, 0, 0, 0, 0, 0), 6'b000001, 1'b0};
    tbl[14] = '{20'h80000,    1'b1, dv6(0, 8, 0, 0, 0, 0), 6'b011111, 1'b0};
    tbl[15] = '{20'hFFFFF,    1'b1, dv6(0, 5'hF, 5'hF, 5'hF, 5'hF, 5'hF), 6'b011111, 1'b0};

    // Reset state: everything low, display blank.
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",     bus.busy,         1'b0);
    check("rst_done",     bus.done,         1'b0);
    check("rst_overflow", bus.overflow,     1'b0);
    check("rst_dv",       bus.digit_value,  '0);
    check("rst_en",       bus.digit_enable, '0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      e.dv = tbl[i].dv; e.en = tbl[i].en; e.ovf = tbl[i].ovf;
      convert(tbl[i].value, tbl[i].hex, e);
    end

    for (int i = 0; i < 8; i++) begin
      rv = 20'($urandom);
      rh = 1'($urandom_range(0, 1));
      convert(rv, rh, model(rv, rh));
    end

    // Start pulsed at N+5 with a different value is ignored.
    @(negedge clk);
    bus.value = 20'd12345; bus.hex_mode = 1'b0; bus.start = 1'b1;
    sb_q.push_back('{dv6(0, 1, 2, 3, 4, 5), 6'b011111, 1'b0});
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.value = 20'd777; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 5;
    while (bus.done !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("busy_start_latency", n, W + 1);
    extra = 0;
    repeat (W + 5) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
    end
    check("busy_start_ignored", extra, 0);

    // Start held across the FORMAT edge is not taken on that edge.
    @(negedge clk);
    bus.value = 20'h12345; bus.hex_mode = 1'b1; bus.start = 1'b1;
    sb_q.push_back('{dv6(0, 1, 2, 3, 4, 5), 6'b011111, 1'b0});
    @(posedge clk); #1;
    bus.value = 20'h00001;
    @(posedge clk); #1;
    check("fmt_edge_done", bus.done, 1'b1);
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("fmt_edge_start_ignored", bus.busy, 1'b0);
    repeat (3) @(posedge clk);

    // Reset at N+10 kills the conversion; no done ever follows.
    @(negedge clk);
    bus.value = 20'd54321; bus.hex_mode = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", bus.busy,         1'b0);
    check("midrst_en",   bus.digit_enable, '0);
    check("midrst_dv",   bus.digit_value,  '0);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (W + 5) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) extra++;
    end
    check("midrst_no_done", extra, 0);

    // Recovers normally after the aborted conversion.
    convert(20'(-42), 1'b0, '{dv6(0, 0, 0, M, 4, 2), 6'b000111, 1'b0});

    check("sb_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/display_bin_formatter.md
Name: display_bin_formatter

Overview:
- Converts a signed binary value into per-digit 5-bit display codes plus per-digit enables for a bank of seven-segment decoders, one decoder instance per digit.
- Decimal mode uses an iterative double-dabble (shift-add-3) conversion.
- Hex mode slices nibbles directly.
- Adds leading-zero blanking, a minus sign (code 0x10) and overflow indication.
- Sits between datapath and decoder bank; outputs hold the last result until a new conversion completes, so the display never shows partial values.

Parameters:
- WIDTH, 20: input value width (two's complement).
- DIGITS, 6: number of display digits driven.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- value  in  WIDTH  signed input value, captured on the accepted start.
- hex_mode  in  1  1 = hex nibble display, 0 = signed decimal; captured with value.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse on the edge outputs update.
- overflow  out  1  last result did not fit in DIGITS.
- digit_value  out  5*DIGITS  code for digit i in bits [5i+4:5i]; digit 0 = rightmost; codes 0x00-0x0F hex digit, 0x10 minus.
- digit_enable  out  DIGITS  bit i = 1 lights digit i; 0 = blank.

Behaviour:
- Reset (async, rst_n=0) sets:
  - state IDLE.
  - busy=0, done=0, overflow=0.
  - digit_value all 0, digit_enable all 0 (display blank).
  - Reset mid-conversion discards all work.
- States: IDLE, SHIFT, FORMAT.
- IDLE:
  - start=1 at edge N: capture sign = value[WIDTH-1], magnitude = |value| as WIDTH-bit unsigned (most-negative value gives 2^(WIDTH-1)), and hex_mode.
  - Clear the BCD register and shift counter; busy=1 from edge N.
  - Next state: SHIFT if decimal, FORMAT if hex.
- SHIFT:
  - Each edge: add 3 to every BCD digit >=5, then shift {bcd, magnitude} left by 1.
  - After exactly WIDTH shifts (edges N+1..N+WIDTH) go to FORMAT.
  - The BCD register holds ceil(WIDTH*log10(2))+1 digits.
- FORMAT: one edge; registers outputs, done=1 for that cycle only, busy=0, next state IDLE.
- Latency:
  - Decimal: outputs and done at edge N+WIDTH+1.
  - Hex: outputs and done at edge N+1.
- Decimal formatting:
  - Overflow if any BCD digit at index >= DIGITS is nonzero, or sign=1 and BCD digit DIGITS-1 is nonzero.
  - On overflow: all digits = 0x10, all enabled, overflow=1.
  - Otherwise overflow=0. Digit i = BCD digit i. Enable digits 0..k, where k = index of the most significant nonzero digit (k=0 when the value is 0).
  - If sign=1: digit k+1 = 0x10, enabled.
  - All higher digits: value 0, disabled.
- Hex formatting:
  - Digit i = raw captured bits [4i+3:4i], zero-extended past WIDTH.
  - Digits with 4i >= WIDTH are always disabled.
  - Same leading-zero blanking; digit 0 is always enabled.
  - No sign handling; overflow=0.
- start while busy is ignored; the value is not queued.
- start on the same edge that FORMAT completes is ignored; it is accepted the following cycle.
- value changes after capture have no effect on the running conversion.

Test Plan:
- Defaults, decimal, value=12345, start at edge N -> at N+21: done=1 for one cycle; digits 0..4 = 5,4,3,2,1 enabled; digit5 disabled; overflow=0; busy high edges N..N+20.
- Decimal value=-42 -> digit0=2, digit1=4, digit2=0x10, all three enabled; digits 3..5 disabled.
- Decimal value=0 -> only digit0 enabled, code 0.
- Decimal value=-99999 -> digits0..4=9, digit5=0x10, overflow=0.
  - value=-100000 -> all six digits 0x10 enabled, overflow=1.
  - value=-524288 -> overflow=1.
- Hex mode, value=20'hA0F03 -> done at N+1; digits 3,0,F,0,A enabled; digit5 disabled.
  - value=20'h00F00 -> digits 0,0,F enabled; digits 3..5 disabled.
- Robustness:
  - Pulse start again at N+5 with a different value -> ignored; the N+21 result matches the first value.
  - Drop rst_n at N+10 -> immediately busy=0 and digit_enable=0; no done pulse follows.
